// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the memory (slave).
// Request/address/write data are held stable while the request is up; ack is a one-cycle pulse.
interface mem_access_ctrl_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: stalls the pipeline while a load/store is
// outstanding on a variable-latency bus, with a 256-cycle timeout that raises a sticky error.
module mem_access_ctrl (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      MemRead_i,
    input  logic                      MemWrite_i,
    input  logic                      RegWrite_i,
    input  logic                      MemtoReg_i,
    input  logic [31:0]               ALUResult_i,
    input  logic [31:0]               RTdata_i,
    input  logic [4:0]                RDaddr_i,
    mem_access_ctrl_if.master         mem,
    output logic                      stall_o,
    output logic                      RegWrite_o,
    output logic                      MemtoReg_o,
    output logic [31:0]               Memdata_o,
    output logic [31:0]               ALUResult_o,
    output logic [4:0]                RDaddr_o,
    output logic                      err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t      state_r,  state_nxt_s;
    logic [7:0]  cnt_r,    cnt_nxt_s;
    logic [31:0] data_r,   data_nxt_s;
    logic [31:0] addr_r,   addr_nxt_s;
    logic [31:0] wdata_r,  wdata_nxt_s;
    logic        we_r,     we_nxt_s;
    logic        err_r,    err_nxt_s;

    logic        access_s;
    logic        stall_s;
    logic        regwrite_s;
    logic        memtoreg_s;
    logic [31:0] memdata_s;

    assign access_s = MemRead_i | MemWrite_i;

    // State and access registers; reset wins over any state, including an open request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            data_r  <= 32'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            we_r    <= we_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state and pipeline-facing outputs; a store (MemWrite_i) takes precedence over a load.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        we_nxt_s    = we_r;
        err_nxt_s   = err_r;
        stall_s     = 1'b0;
        regwrite_s  = RegWrite_i;
        memtoreg_s  = MemtoReg_i;
        memdata_s   = 32'd0;

        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    stall_s     = 1'b1;
                    regwrite_s  = 1'b0;
                    addr_nxt_s  = ALUResult_i;
                    wdata_nxt_s = RTdata_i;
                    we_nxt_s    = MemWrite_i;
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s    = 1'b1;
                regwrite_s = 1'b0;
                if (mem.mem_ack_i) begin
                    data_nxt_s  = we_r ? 32'd0 : mem.mem_rdata_i;
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == 8'hFF) begin
                    data_nxt_s  = TIMEOUT_DATA;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                memdata_s   = data_r;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // While reset is held the pipeline must not stall or commit a register write.
    assign stall_o     = stall_s    & ~rst_i;
    assign RegWrite_o  = regwrite_s & ~rst_i;
    assign MemtoReg_o  = memtoreg_s & ~rst_i;
    assign Memdata_o   = rst_i ? 32'd0 : memdata_s;
    assign ALUResult_o = ALUResult_i;
    assign RDaddr_o    = RDaddr_i;
    assign err_o       = err_r;

    assign mem.mem_req_o   = (state_r == ST_BUSY);
    assign mem.mem_we_o    = (state_r == ST_BUSY) & we_r;
    assign mem.mem_addr_o  = addr_r;
    assign mem.mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a transaction-level memory model predicts
// stall length, load data, store zeroing, timeout data and the sticky error flag.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] ALUResult, RTdata;
    logic [4:0]  RDaddr;
    logic        stall, RegWrite_o, MemtoReg_o, err;
    logic [31:0] Memdata_o, ALUResult_o;
    logic [4:0]  RDaddr_o;

    mem_access_ctrl_if mem_bus();

    mem_access_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .MemRead_i   (MemRead),
        .MemWrite_i  (MemWrite),
        .RegWrite_i  (RegWrite),
        .MemtoReg_i  (MemtoReg),
        .ALUResult_i (ALUResult),
        .RTdata_i    (RTdata),
        .RDaddr_i    (RDaddr),
        .mem         (mem_bus),
        .stall_o     (stall),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .Memdata_o   (Memdata_o),
        .ALUResult_o (ALUResult_o),
        .RDaddr_o    (RDaddr_o),
        .err_o       (err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        err_exp  = 1'b0;
    logic [31:0] mem_model [logic [31:0]];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic alu_op(input logic rw, input logic mtr, input logic [31:0] alu, input logic [4:0] rd);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = rw; MemtoReg = mtr;
        ALUResult = alu; RTdata = $urandom; RDaddr = rd;
        mem_bus.mem_ack_i = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata_i = $urandom;
        @(negedge clk);
        check_eq("alu_stall", 32'(stall), 32'd0);
        check_eq("alu_regwrite", 32'(RegWrite_o), 32'(rw));
        check_eq("alu_memtoreg", 32'(MemtoReg_o), 32'(mtr));
        check_eq("alu_memdata", Memdata_o, 32'd0);
        check_eq("alu_result", ALUResult_o, alu);
        check_eq("alu_rdaddr", 32'(RDaddr_o), 32'(rd));
        check_eq("alu_req", 32'(mem_bus.mem_req_o), 32'd0);
        check_eq("alu_err", 32'(err), 32'(err_exp));
    endtask

    // One load/store; ack arrives in BUSY cycle number ack_delay+1 (never if >= 256).
    task automatic access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input logic rw,
                          input logic mtr, input int ack_delay);
        int          busy;
        logic        acked;
        logic [31:0] exp_data;
        @(posedge clk); #1;
        MemRead = rd_en; MemWrite = wr_en; RegWrite = rw; MemtoReg = mtr;
        ALUResult = addr; RTdata = wdata; RDaddr = rd;
        mem_bus.mem_ack_i = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata_i = $urandom;
        @(negedge clk);
        check_eq("detect_stall", 32'(stall), 32'd1);
        check_eq("detect_regwrite", 32'(RegWrite_o), 32'd0);
        check_eq("detect_req", 32'(mem_bus.mem_req_o), 32'd0);
        check_eq("detect_alu", ALUResult_o, addr);
        busy  = 0;
        acked = 1'b0;
        while (!acked && busy < 256) begin
            @(posedge clk); #1;
            acked = (busy == ack_delay);
            busy++;
            mem_bus.mem_ack_i   = acked;
            mem_bus.mem_rdata_i = (acked && !wr_en) ? mem_peek(addr) : $urandom;
            @(negedge clk);
            check_eq("busy_req", 32'(mem_bus.mem_req_o), 32'd1);
            check_eq("busy_we", 32'(mem_bus.mem_we_o), 32'(wr_en));
            check_eq("busy_addr", mem_bus.mem_addr_o, addr);
            check_eq("busy_wdata", mem_bus.mem_wdata_o, wdata);
            check_eq("busy_stall", 32'(stall), 32'd1);
            check_eq("busy_regwrite", 32'(RegWrite_o), 32'd0);
        end
        if (!acked) begin
            exp_data = 32'hDEAD_BEEF;
            err_exp  = 1'b1;
        end else if (wr_en) begin
            exp_data = 32'd0;
            mem_model[addr] = wdata;
        end else begin
            exp_data = mem_peek(addr);
        end
        @(posedge clk); #1;
        mem_bus.mem_ack_i = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata_i = $urandom;
        @(negedge clk);
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("done_req", 32'(mem_bus.mem_req_o), 32'd0);
        check_eq("done_we", 32'(mem_bus.mem_we_o), 32'd0);
        check_eq("done_regwrite", 32'(RegWrite_o), 32'(rw));
        check_eq("done_memtoreg", 32'(MemtoReg_o), 32'(mtr));
        check_eq("done_memdata", Memdata_o, exp_data);
        check_eq("done_rdaddr", 32'(RDaddr_o), 32'(rd));
        check_eq("done_err", 32'(err), 32'(err_exp));
    endtask

    task automatic reset_mid_busy();
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
        ALUResult = 32'h0000_0C00; RTdata = 32'h1111_2222; RDaddr = 5'd9;
        mem_bus.mem_ack_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy_stall", 32'(stall), 32'd0);
        check_eq("rst_busy_regwrite", 32'(RegWrite_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; MemRead = 1'b0;
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h7777_7777;
        err_exp = 1'b0;
        @(negedge clk);
        check_eq("rst_req", 32'(mem_bus.mem_req_o), 32'd0);
        check_eq("rst_we", 32'(mem_bus.mem_we_o), 32'd0);
        check_eq("rst_addr", mem_bus.mem_addr_o, 32'd0);
        check_eq("rst_wdata", mem_bus.mem_wdata_o, 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_memdata", Memdata_o, 32'd0);
        @(posedge clk); #1;
        mem_bus.mem_ack_i = 1'b0;
        @(negedge clk);
        check_eq("late_ack_req", 32'(mem_bus.mem_req_o), 32'd0);
        check_eq("late_ack_memdata", Memdata_o, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        int          dly;
        logic [31:0] a;
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
        ALUResult = 32'd0; RTdata = 32'd0; RDaddr = 5'd0;
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_stall", 32'(stall), 32'd0);
        check_eq("reset_regwrite", 32'(RegWrite_o), 32'd0);
        check_eq("reset_req", 32'(mem_bus.mem_req_o), 32'd0);
        check_eq("reset_addr", mem_bus.mem_addr_o, 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        alu_op(1'b1, 1'b0, 32'h0000_0010, 5'd3);
        mem_model[32'h40] = 32'h1234_5678;
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd4, 1'b1, 1'b1, 0);
        access(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 4);
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd5, 1'b1, 1'b1, 2);
        access(1'b1, 1'b1, 32'h0000_0084, 32'hABCD_0123, 5'd6, 1'b0, 1'b0, 1);
        access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 5'd7, 1'b1, 1'b1, 0);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b1, 1000);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd8, 1'b1, 1'b1, 255);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd8, 1'b1, 1'b1, 3);
        alu_op(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31);
        reset_mid_busy();

        for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 3);
            a   = 32'h0000_0200 + 32'($urandom_range(0, 7)) * 32'd4;
            dly = ($urandom_range(0, 24) == 0) ? 300 : $urandom_range(0, 8);
            case (op)
                0: alu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 5'($urandom));
                1: access(1'b1, 1'b0, a, $urandom, 5'($urandom), 1'b1, 1'b1, dly);
                2: access(1'b0, 1'b1, a, $urandom, 5'($urandom), 1'b0, 1'b0, dly);
                default: access(1'b1, 1'b1, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1'b0, dly);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i, rst_i.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 MemRead_i  in  1  load in MEM stage (from EX/MEM).
REQ-005 MemWrite_i  in  1  store in MEM stage.
REQ-006 RegWrite_i  in  1  instruction writes register file.
REQ-007 MemtoReg_i  in  1  writeback selects memory data.
REQ-008 ALUResult_i  in  32  ALU result, also the memory address.
REQ-009 RTdata_i  in  32  store data.
REQ-010 RDaddr_i  in  5  destination register.
REQ-011 mem_req_o / mem_we_o  out  1 / 1  data-memory request / write enable.
REQ-012 mem_addr_o / mem_wdata_o  out  32 / 32  registered address / store data.
REQ-013 mem_ack_i  in  1  memory completion, one-cycle pulse.
REQ-014 mem_rdata_i  in  32  load data, valid when mem_ack_i=1.
REQ-015 stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-016 RegWrite_o, MemtoReg_o  out  1, 1  to MEM/WB.
REQ-017 Memdata_o, ALUResult_o  out  32, 32  to MEM/WB.
REQ-018 RDaddr_o  out  5  to MEM/WB; err_o  out  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-020 access = MemRead_i | MemWrite_i; both high SHALL be treated as a store.
REQ-021 IDLE, access=0: stall_o=0; RegWrite_o=RegWrite_i, MemtoReg_o=MemtoReg_i, Memdata_o=0; stay IDLE.
REQ-022 IDLE, access=1: stall_o=1, RegWrite_o=0 (bubble); latch ALUResult_i, RTdata_i, MemWrite_i into mem_addr_o, mem_wdata_o, mem_we_o; clear wait counter; next BUSY.
REQ-023 BUSY: mem_req_o=1, stall_o=1, RegWrite_o=0; addr/wdata/we held stable.
REQ-024 BUSY, mem_ack_i=1: capture mem_rdata_i (load) or 0 (store) into data register; next DONE.
REQ-025 BUSY, mem_ack_i=0: 8-bit wait counter increments; at 8'hFF with no ack, data register=32'hDEADBEEF, err_o set, next DONE (max 256 BUSY cycles).
REQ-026 DONE: mem_req_o=0, stall_o=0; RegWrite_o=RegWrite_i, MemtoReg_o=MemtoReg_i, Memdata_o=data register; next IDLE unconditionally.
REQ-027 ALUResult_o=ALUResult_i and RDaddr_o=RDaddr_i combinationally in all states.
REQ-028 mem_req_o, mem_we_o SHALL be 0 outside BUSY; mem_ack_i outside BUSY SHALL be ignored.
REQ-029 Minimum access latency: 2 stall cycles (IDLE-detect, BUSY with ack), result presented in DONE cycle.
REQ-030 Back-to-back accesses: DONE->IDLE then new access detected in IDLE; no request merging.
REQ-031 err_o SHALL remain 1 until reset; it does not block later accesses.

Reset
REQ-032 rst_i=1 SHALL force IDLE, counter=0, data register=0, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, mem_req_o=0, err_o=0, regardless of state.
REQ-033 Reset during BUSY SHALL drop mem_req_o the next cycle; a late ack SHALL be ignored.
REQ-034 During reset, stall_o=0 and RegWrite_o=0.

Verification
REQ-035 ALU op (RegWrite_i=1, access=0, ALUResult_i=0x10) -> stall_o=0, RegWrite_o=1, ALUResult_o=0x10, no mem_req_o.
REQ-036 Load addr 0x40, ack in first BUSY cycle with rdata 0x12345678 -> stall_o=1 two cycles, DONE Memdata_o=0x12345678, RegWrite_o=1.
REQ-037 Store addr 0x80 data 0xCAFEF00D, ack after 5 BUSY cycles -> mem_we_o=1, addr/data stable 5 cycles, stall 6 cycles, Memdata_o=0.
REQ-038 Load, no ack -> 256 BUSY cycles, then Memdata_o=0xDEADBEEF, err_o=1 persists; next load with ack completes normally.
REQ-039 rst_i pulsed in 3rd BUSY cycle, ack next cycle -> IDLE, mem_req_o=0, ack ignored, all outputs at reset values.
REQ-040 MemRead_i=MemWrite_i=1 -> mem_we_o=1 (store), Memdata_o=0.
